// File: rtl/fetch_queue.sv
// fetch_queue: fetch-bundle FIFO between the fetch unit and the IF/ID register.
// Lets I-cache fetch run ahead of decode back-pressure.
//
// The head entry is presented first-word-fall-through. When the queue is
// empty, a bubble is presented instead: pc, recv_pc and pred are 0, and inst
// is NOP_INST.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   fetch_valid              fetch unit presents a bundle
//   pc/inst/recv_pc_fetch_in bundle payload; pred_result_in carries the
//                            per-slot prediction bits
//   fetch_ready              queue can accept a push (= ~full)
//   stall                    head is held (not consumed) while high
//   flush                    empties the queue at the next edge
//   *_to_dec                 head payload, or the bubble when empty
//   q_valid                  head valid (= ~empty)
//   q_count                  occupancy, 0..DEPTH
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [63:0] NOP_INST = 64'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [63:0]      pc_fetch_in,
  input  logic [63:0]      inst_fetch_in,
  input  logic [63:0]      recv_pc_fetch_in,
  input  logic [3:0]       pred_result_in,
  output logic             fetch_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [63:0]      pc_to_dec,
  output logic [63:0]      inst_to_dec,
  output logic [63:0]      recv_pc_to_dec,
  output logic [3:0]       pred_result_to_dec,
  output logic             q_valid,
  output logic [PTR_W:0]   q_count
);

  // 196-bit entry
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] inst;
    logic [63:0] recv_pc;
    logic [3:0]  pred;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]     r_count;

  logic   w_full, w_empty, w_push, w_pop;
  entry_t w_head;

  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // Flush wins over both sides; a bundle offered alongside flush is dropped.
  assign w_push  = fetch_valid & ~w_full & ~flush;
  assign w_pop   = ~w_empty & ~stall & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{pc: pc_fetch_in, inst: inst_fetch_in,
                                     recv_pc: recv_pc_fetch_in, pred: pred_result_in};
  end

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    pc_to_dec          = 64'h0;
    inst_to_dec        = NOP_INST;
    recv_pc_to_dec     = 64'h0;
    pred_result_to_dec = 4'h0;
    if (!w_empty) begin
      pc_to_dec          = w_head.pc;
      inst_to_dec        = w_head.inst;
      recv_pc_to_dec     = w_head.recv_pc;
      pred_result_to_dec = w_head.pred;
    end
  end

  assign fetch_ready = ~w_full;
  assign q_valid     = ~w_empty;
  assign q_count     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam logic [63:0] NOP = 64'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [63:0] pc_fetch_in, inst_fetch_in, recv_pc_fetch_in;
  logic [3:0]  pred_result_in;
  logic        fetch_ready, stall, flush, q_valid;
  logic [63:0] pc_to_dec, inst_to_dec, recv_pc_to_dec;
  logic [3:0]  pred_result_to_dec;
  logic [2:0]  q_count;

  fetch_queue #(.DEPTH(4), .PTR_W(2), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid),
    .pc_fetch_in(pc_fetch_in), .inst_fetch_in(inst_fetch_in),
    .recv_pc_fetch_in(recv_pc_fetch_in), .pred_result_in(pred_result_in),
    .fetch_ready(fetch_ready), .stall(stall), .flush(flush),
    .pc_to_dec(pc_to_dec), .inst_to_dec(inst_to_dec),
    .recv_pc_to_dec(recv_pc_to_dec), .pred_result_to_dec(pred_result_to_dec),
    .q_valid(q_valid), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] inst;
    logic [63:0] rpc;
    logic [3:0]  pred;
  } bnd_t;

  // Reference: a plain queue of bundles, head at index 0.
  bnd_t model[$];

  function automatic bnd_t mk(input logic [63:0] pc);
    bnd_t b;
    b.pc   = pc;
    b.inst = pc ^ 64'h5A5A_0F0F_C3C3_9696;
    b.rpc  = pc + 64'h40;
    b.pred = pc[6:3] ^ 4'h9;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit fv, input bit st, input bit fl, input logic [63:0] pc);
    bnd_t b;
    b = mk(pc);
    fetch_valid      = fv;
    stall            = st;
    flush            = fl;
    pc_fetch_in      = b.pc;
    inst_fetch_in    = b.inst;
    recv_pc_fetch_in = b.rpc;
    pred_result_in   = b.pred;
  endtask

  // One clock edge. The model advances using the inputs seen at the edge,
  // and the task returns 1 time unit later, which is when outputs are sampled.
  task automatic tick();
    bit full, push, pop;
    @(posedge clk);
    if (!rst) begin
      full = (model.size() == 4);
      push = fetch_valid && !full && !flush;
      pop  = (model.size() > 0) && !stall && !flush;
      if (flush) model.delete();
      else begin
        if (pop)  void'(model.pop_front());
        if (push) model.push_back(mk(pc_fetch_in));
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    bnd_t h;
    bit   e;
    e = (model.size() == 0);
    h = e ? '{pc: 64'h0, inst: NOP, rpc: 64'h0, pred: 4'h0} : model[0];
    chk({tag, ".count"}, 64'(q_count), 64'(model.size()));
    chk({tag, ".valid"}, 64'(q_valid), 64'(!e));
    chk({tag, ".ready"}, 64'(fetch_ready), 64'(model.size() != 4));
    chk({tag, ".pc"},    pc_to_dec, h.pc);
    chk({tag, ".inst"},  inst_to_dec, h.inst);
    chk({tag, ".rpc"},   recv_pc_to_dec, h.rpc);
    chk({tag, ".pred"},  64'(pred_result_to_dec), 64'(h.pred));
  endtask

  typedef struct {
    bit          fv, st, fl;
    logic [63:0] pc;
    int          cnt;
    bit          rdy;
    logic [63:0] epc;
  } vec_t;

  vec_t tbl[24];

  initial begin
    bnd_t eb;
    // Each row: inputs applied for one edge, then the expected state after it.
    tbl[0]  = '{1,0,0,64'h10, 1,1,64'h10};
    tbl[1]  = '{1,0,0,64'h18, 1,1,64'h18};
    tbl[2]  = '{1,0,0,64'h20, 1,1,64'h20};
    tbl[3]  = '{0,0,0,64'h0,  0,1,64'h0};
    tbl[4]  = '{1,1,0,64'h100,1,1,64'h100};
    tbl[5]  = '{1,1,0,64'h108,2,1,64'h100};
    tbl[6]  = '{1,1,0,64'h110,3,1,64'h100};
    tbl[7]  = '{1,1,0,64'h118,4,0,64'h100};
    tbl[8]  = '{1,1,0,64'h120,4,0,64'h100};  // ignored while full
    tbl[9]  = '{0,0,0,64'h0,  3,1,64'h108};
    tbl[10] = '{0,0,0,64'h0,  2,1,64'h110};
    tbl[11] = '{0,0,0,64'h0,  1,1,64'h118};
    tbl[12] = '{0,0,0,64'h0,  0,1,64'h0};
    tbl[13] = '{1,1,0,64'h200,1,1,64'h200};
    tbl[14] = '{1,1,0,64'h208,2,1,64'h200};
    tbl[15] = '{1,0,0,64'h210,2,1,64'h208};
    tbl[16] = '{1,0,0,64'h218,2,1,64'h210};
    tbl[17] = '{1,0,0,64'h220,2,1,64'h218};
    tbl[18] = '{1,0,0,64'h228,2,1,64'h220};
    tbl[19] = '{1,0,0,64'h230,2,1,64'h228};
    tbl[20] = '{1,0,0,64'h238,2,1,64'h230};
    tbl[21] = '{1,1,0,64'h240,3,1,64'h230};
    tbl[22] = '{1,0,1,64'h248,0,1,64'h0};    // flush drops the push
    tbl[23] = '{0,0,0,64'h0,  0,1,64'h0};

    rst = 1'b1;
    drive(0, 0, 0, 64'h0);
    #12;
    chk("reset.count", 64'(q_count), 64'd0);
    chk("reset.valid", 64'(q_valid), 64'd0);
    chk("reset.ready", 64'(fetch_ready), 64'd1);
    chk("reset.inst",  inst_to_dec, NOP);
    chk("reset.pc",    pc_to_dec, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table: first-bundle latency, fill/full, drain, wrap, flush.
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].fv, tbl[i].st, tbl[i].fl, tbl[i].pc);
      tick();
      eb = mk(tbl[i].epc);
      chk($sformatf("vec%0d.count", i), 64'(q_count), 64'(tbl[i].cnt));
      chk($sformatf("vec%0d.valid", i), 64'(q_valid), 64'(tbl[i].cnt != 0));
      chk($sformatf("vec%0d.ready", i), 64'(fetch_ready), 64'(tbl[i].rdy));
      chk($sformatf("vec%0d.pc", i),    pc_to_dec, tbl[i].epc);
      chk($sformatf("vec%0d.inst", i),  inst_to_dec, (tbl[i].cnt != 0) ? eb.inst : NOP);
      chk($sformatf("vec%0d.rpc", i),   recv_pc_to_dec, (tbl[i].cnt != 0) ? eb.rpc : 64'h0);
    end

    // Async reset mid-cycle at count=2, then normal pushes resume.
    model.delete();
    drive(1, 1, 0, 64'h300); tick();
    drive(1, 1, 0, 64'h308); tick();
    check_model("prerst");
    #2 rst = 1'b1;
    model.delete();
    #1;
    chk("arst.count", 64'(q_count), 64'd0);
    chk("arst.valid", 64'(q_valid), 64'd0);
    chk("arst.pc",    pc_to_dec, 64'h0);
    chk("arst.inst",  inst_to_dec, NOP);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 64'h400 + 64'(i * 8));
      tick();
      check_model($sformatf("post%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 64'h0);
      tick();
      check_model($sformatf("drain%0d", i));
    end

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
            $urandom_range(0, 24) == 0, {$urandom, $urandom});
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
